// File: rtl/adc_ts_packer.sv
// Merges an ADC byte stream and a timestamp byte stream into one framed byte stream (header + payload).
// Latency: one cycle from an accepted input byte to o_m_axis_tdata; the header is loaded without consuming input.
// Backpressure: a single output register; an input is accepted only when that register is empty or draining.
module adc_ts_packer #(
    parameter int          PKT_LEN_WIDTH = 8,
    parameter logic [3:0]  ADC_HDR_TYPE  = 4'hA,
    parameter logic [3:0]  TS_HDR_TYPE   = 4'h5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [PKT_LEN_WIDTH-1:0] i_adc_pkt_len,
    input  logic [7:0]               i_s_axis_adc_tdata,
    input  logic                     i_s_axis_adc_tkeep,
    input  logic                     i_s_axis_adc_tvalid,
    input  logic                     i_s_axis_adc_tlast,
    output logic                     o_s_axis_adc_tready,
    input  logic [7:0]               i_s_axis_ts_tdata,
    input  logic                     i_s_axis_ts_tkeep,
    input  logic                     i_s_axis_ts_tvalid,
    input  logic                     i_s_axis_ts_tlast,
    output logic                     o_s_axis_ts_tready,
    output logic [7:0]               o_m_axis_tdata,
    output logic                     o_m_axis_tvalid,
    output logic                     o_m_axis_tlast,
    input  logic                     i_m_axis_tready,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADC_PAY = 2'd1,
        TS_PAY  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [7:0]               out_dat_q, out_dat_d;
    logic                     out_vld_q, out_vld_d;
    logic                     out_last_q, out_last_d;
    logic [3:0]               seq_adc_q, seq_adc_d;
    logic [3:0]               seq_ts_q, seq_ts_d;
    logic [PKT_LEN_WIDTH-1:0] len_q, len_d;
    logic [PKT_LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                     drain_ok;

    // ADC tlast is ignored (length comes from i_adc_pkt_len); TS tkeep is ignored (every TS byte is forwarded).
    logic unused_inputs;
    assign unused_inputs = i_s_axis_adc_tlast ^ i_s_axis_ts_tkeep;

    // The output register can take a new byte when it is empty or its current byte leaves this cycle.
    assign drain_ok = !out_vld_q || i_m_axis_tready;

    // State and datapath registers, synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            out_dat_q  <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            seq_adc_q  <= '0;
            seq_ts_q   <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_dat_q  <= out_dat_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            seq_adc_q  <= seq_adc_d;
            seq_ts_q   <= seq_ts_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic: packet-boundary arbitration (TS first), header load and payload forwarding.
    always_comb begin
        state_d    = state_q;
        out_dat_d  = out_dat_q;
        out_vld_d  = out_vld_q && !i_m_axis_tready;
        out_last_d = out_last_q;
        seq_adc_d  = seq_adc_q;
        seq_ts_d   = seq_ts_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (drain_ok) begin
                    if (i_s_axis_ts_tvalid) begin
                        out_vld_d  = 1'b1;
                        out_dat_d  = {TS_HDR_TYPE, seq_ts_q};
                        out_last_d = 1'b0;
                        seq_ts_d   = seq_ts_q + 4'd1;
                        state_d    = TS_PAY;
                    end else if (i_s_axis_adc_tvalid) begin
                        out_vld_d  = 1'b1;
                        out_dat_d  = {ADC_HDR_TYPE, seq_adc_q};
                        out_last_d = 1'b0;
                        seq_adc_d  = seq_adc_q + 4'd1;
                        len_d      = i_adc_pkt_len;
                        cnt_d      = '0;
                        state_d    = ADC_PAY;
                    end
                end
            end
            ADC_PAY: begin
                // A tkeep=0 byte is still accepted (tready high) but dropped and not counted.
                if (i_s_axis_adc_tvalid && drain_ok && i_s_axis_adc_tkeep) begin
                    out_vld_d  = 1'b1;
                    out_dat_d  = i_s_axis_adc_tdata;
                    out_last_d = (cnt_q == len_q);
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                    end
                end
            end
            TS_PAY: begin
                if (i_s_axis_ts_tvalid && drain_ok) begin
                    out_vld_d  = 1'b1;
                    out_dat_d  = i_s_axis_ts_tdata;
                    out_last_d = i_s_axis_ts_tlast;
                    if (i_s_axis_ts_tlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: input readies only in the matching payload state, busy outside IDLE.
    always_comb begin
        o_s_axis_adc_tready = (state_q == ADC_PAY) && drain_ok;
        o_s_axis_ts_tready  = (state_q == TS_PAY) && drain_ok;
        o_busy              = (state_q != IDLE);
        o_m_axis_tdata      = out_dat_q;
        o_m_axis_tvalid     = out_vld_q;
        o_m_axis_tlast      = out_last_q;
    end

endmodule

// File: tb/tb_adc_ts_packer.sv
// Directed bench for adc_ts_packer: collects every output byte handed downstream and
// compares it with a hand-written expected sequence; also checks reset values and stall stability.
module tb_adc_ts_packer;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_adc_pkt_len = 8'd0;
    logic [7:0] adc_tdata = 8'd0;
    logic       adc_tkeep = 1'b0;
    logic       adc_tvalid = 1'b0;
    logic       adc_tlast = 1'b0;
    logic       adc_tready;
    logic [7:0] ts_tdata = 8'd0;
    logic       ts_tkeep = 1'b0;
    logic       ts_tvalid = 1'b0;
    logic       ts_tlast = 1'b0;
    logic       ts_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tlast;
    logic       m_tready = 1'b1;
    logic       busy;

    adc_ts_packer dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_adc_pkt_len       (i_adc_pkt_len),
        .i_s_axis_adc_tdata  (adc_tdata),
        .i_s_axis_adc_tkeep  (adc_tkeep),
        .i_s_axis_adc_tvalid (adc_tvalid),
        .i_s_axis_adc_tlast  (adc_tlast),
        .o_s_axis_adc_tready (adc_tready),
        .i_s_axis_ts_tdata   (ts_tdata),
        .i_s_axis_ts_tkeep   (ts_tkeep),
        .i_s_axis_ts_tvalid  (ts_tvalid),
        .i_s_axis_ts_tlast   (ts_tlast),
        .o_s_axis_ts_tready  (ts_tready),
        .o_m_axis_tdata      (m_tdata),
        .o_m_axis_tvalid     (m_tvalid),
        .o_m_axis_tlast      (m_tlast),
        .i_m_axis_tready     (m_tready),
        .o_busy              (busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int         c;
        logic       l;
        logic [7:0] d;
    } ob_t;

    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         bp_en = 1'b0;
    ob_t        got_q[$];
    logic [8:0] exp_q[$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_dat = 8'd0;
    logic       prev_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Randomised downstream ready when enabled, otherwise held high.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: records handshakes and checks held data while stalled.
    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_vld", {31'd0, m_tvalid}, 32'd1);
                chk("stall_dat", {23'd0, m_tlast, m_tdata}, {23'd0, prev_last, prev_dat});
            end
            if (m_tvalid && m_tready) got_q.push_back('{cyc, m_tlast, m_tdata});
            prev_stall = m_tvalid && !m_tready;
            prev_dat   = m_tdata;
            prev_last  = m_tlast;
        end
    end

    task automatic expect_b(input logic [7:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic adc_send(input logic [7:0] d, input logic k);
        int t = 0;
        adc_tvalid = 1'b1;
        adc_tdata  = d;
        adc_tkeep  = k;
        adc_tlast  = 1'b0;
        forever begin
            @(negedge i_clk);
            if (adc_tready || t > 1000) break;
            t++;
        end
        chk("adc_wait_timeout", {31'd0, t > 1000}, 32'd0);
        @(posedge i_clk);
        #1;
        adc_tvalid = 1'b0;
    endtask

    task automatic ts_send(input logic [7:0] d, input logic k, input logic l);
        int t = 0;
        ts_tvalid = 1'b1;
        ts_tdata  = d;
        ts_tkeep  = k;
        ts_tlast  = l;
        forever begin
            @(negedge i_clk);
            if (ts_tready || t > 1000) break;
            t++;
        end
        chk("ts_wait_timeout", {31'd0, t > 1000}, 32'd0);
        @(posedge i_clk);
        #1;
        ts_tvalid = 1'b0;
        ts_tlast  = 1'b0;
    endtask

    task automatic check_stream(input string tag, input bit contiguous);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 5000) begin
            @(posedge i_clk);
            t++;
        end
        repeat (3) @(posedge i_clk);
        #1;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_byte"}, {23'd0, got_q[i].l, got_q[i].d}, {23'd0, exp_q[i]});
            if (contiguous && i > 0) chk({tag, "_gap"}, got_q[i].c - got_q[i-1].c, 32'd1);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_tdata", {24'd0, m_tdata}, 32'd0);
        chk("rst_adc_rdy", {31'd0, adc_tready}, 32'd0);
        chk("rst_ts_rdy", {31'd0, ts_tready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        i_rst = 1'b0;

        // Two back-to-back 4-byte ADC packets at full rate
        do_reset();
        i_adc_pkt_len = 8'd3;
        for (int i = 1; i <= 8; i++) adc_send(8'(i), 1'b1);
        expect_b(8'hA0, 0); expect_b(8'h01, 0); expect_b(8'h02, 0); expect_b(8'h03, 0); expect_b(8'h04, 1);
        expect_b(8'hA1, 0); expect_b(8'h05, 0); expect_b(8'h06, 0); expect_b(8'h07, 0); expect_b(8'h08, 1);
        check_stream("adc_b2b", 1'b1);

        // tkeep=0 byte is consumed but dropped
        do_reset();
        i_adc_pkt_len = 8'd1;
        adc_send(8'h11, 1'b1);
        adc_send(8'h22, 1'b0);
        adc_send(8'h33, 1'b1);
        expect_b(8'hA0, 0); expect_b(8'h11, 0); expect_b(8'h33, 1);
        check_stream("adc_keep", 1'b0);

        // Single-byte packet (length field 0)
        i_adc_pkt_len = 8'd0;
        adc_send(8'h5A, 1'b1);
        expect_b(8'hA1, 0); expect_b(8'h5A, 1);
        check_stream("adc_len0", 1'b0);

        // Simultaneous TS and ADC in IDLE: TS wins, ADC held off
        do_reset();
        i_adc_pkt_len = 8'd3;
        fork
            begin
                ts_send(8'hDE, 1'b0, 1'b0);
                ts_send(8'hAD, 1'b1, 1'b0);
                ts_send(8'hBE, 1'b1, 1'b0);
                ts_send(8'hEF, 1'b1, 1'b1);
            end
            begin
                for (int i = 1; i <= 4; i++) adc_send(8'(i), 1'b1);
            end
            begin
                repeat (6) begin
                    @(negedge i_clk);
                    if (ts_tready) chk("adc_rdy_during_ts", {31'd0, adc_tready}, 32'd0);
                end
            end
        join
        expect_b(8'h50, 0); expect_b(8'hDE, 0); expect_b(8'hAD, 0); expect_b(8'hBE, 0); expect_b(8'hEF, 1);
        expect_b(8'hA0, 0); expect_b(8'h01, 0); expect_b(8'h02, 0); expect_b(8'h03, 0); expect_b(8'h04, 1);
        check_stream("ts_prio", 1'b1);

        // TS arriving mid ADC packet waits for the packet boundary
        do_reset();
        i_adc_pkt_len = 8'd3;
        fork
            begin
                for (int i = 1; i <= 4; i++) adc_send(8'(i), 1'b1);
            end
            begin
                repeat (3) @(posedge i_clk);
                #1;
                ts_send(8'h77, 1'b1, 1'b0);
                ts_send(8'h88, 1'b1, 1'b1);
            end
        join
        expect_b(8'hA0, 0); expect_b(8'h01, 0); expect_b(8'h02, 0); expect_b(8'h03, 0); expect_b(8'h04, 1);
        expect_b(8'h50, 0); expect_b(8'h77, 0); expect_b(8'h88, 1);
        check_stream("ts_mid_adc", 1'b1);

        // 20 ADC packets under random downstream backpressure; sequence nibble wraps
        do_reset();
        i_adc_pkt_len = 8'd2;
        bp_en = 1'b1;
        for (int p = 0; p < 20; p++) begin
            for (int j = 0; j < 3; j++) adc_send(8'(p * 3 + j), 1'b1);
        end
        for (int p = 0; p < 20; p++) begin
            expect_b({4'hA, 4'(p)}, 0);
            for (int j = 0; j < 3; j++) expect_b(8'(p * 3 + j), j == 2);
        end
        check_stream("bp_wrap", 1'b0);
        bp_en = 1'b0;

        // Reset in the middle of a packet
        do_reset();
        i_adc_pkt_len = 8'd3;
        adc_send(8'h01, 1'b1);
        adc_send(8'h02, 1'b1);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        chk("mrst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("mrst_tlast", {31'd0, m_tlast}, 32'd0);
        chk("mrst_tdata", {24'd0, m_tdata}, 32'd0);
        chk("mrst_adc_rdy", {31'd0, adc_tready}, 32'd0);
        chk("mrst_ts_rdy", {31'd0, ts_tready}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        i_rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        for (int i = 5; i <= 8; i++) adc_send(8'(i), 1'b1);
        expect_b(8'hA0, 0); expect_b(8'h05, 0); expect_b(8'h06, 0); expect_b(8'h07, 0); expect_b(8'h08, 1);
        check_stream("after_rst", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
